// File: rtl/fxp_calc.sv
// Fixed-point requantizer: aligns the binary point, floors the discarded bits and
// clamps to the output range. One-cycle registered latency.
package fxp_pkg;
  typedef enum logic {INT, FXP} dtype_t;

  typedef struct packed {
    dtype_t      dtype;
    logic        sign;
    int unsigned prec;
    int unsigned frac;
  } dconf_t;
endpackage

module fxp_calc #(
  parameter fxp_pkg::dconf_t I_CONF = '{dtype: fxp_pkg::FXP, sign: 1'b1, prec: 16, frac: 4},
  parameter fxp_pkg::dconf_t O_CONF = '{dtype: fxp_pkg::FXP, sign: 1'b1, prec: 8,  frac: 3}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [I_CONF.prec-1:0] in,
  output logic                   out_valid,
  output logic [O_CONF.prec-1:0] out,
  output logic                   ovf,
  output logic                   udf,
  output logic                   rounded
);
  localparam int unsigned IP = I_CONF.prec;
  localparam int unsigned OP = O_CONF.prec;
  localparam int unsigned IF = (I_CONF.dtype == fxp_pkg::FXP) ? I_CONF.frac : 0;
  localparam int unsigned OF = (O_CONF.dtype == fxp_pkg::FXP) ? O_CONF.frac : 0;
  localparam int          D  = int'(IF) - int'(OF);
  localparam int unsigned LS = (D < 0) ? unsigned'(-D) : 0;
  localparam int unsigned RS = (D > 0) ? unsigned'(D) : 0;
  // Two spare bits: one so unsigned inputs stay non-negative, one of headroom for the range compare.
  localparam int unsigned W  = ((IP + LS > OP) ? IP + LS : OP) + 2;

  localparam logic signed [W-1:0] OMAX = O_CONF.sign ? (W'(1) << (OP - 1)) - W'(1)
                                                     : (W'(1) << OP) - W'(1);
  localparam logic signed [W-1:0] OMIN = O_CONF.sign ? -(W'(1) << (OP - 1)) : '0;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] aligned;
  logic                lost;
  logic [OP-1:0]       nxt_out;
  logic                nxt_ovf;
  logic                nxt_udf;
  logic                nxt_rnd;

  always_comb begin
    ext     = {{(W - IP){in[IP-1] & I_CONF.sign}}, in};
    aligned = (ext <<< LS) >>> RS;
    // Shifting back and comparing detects any nonzero discarded bit, including RS >= W.
    lost    = ((aligned <<< RS) != (ext <<< LS));
    nxt_out = aligned[OP-1:0];
    nxt_ovf = 1'b0;
    nxt_udf = 1'b0;
    nxt_rnd = 1'b0;
    if (aligned > OMAX) begin
      nxt_out = OMAX[OP-1:0];
      nxt_ovf = 1'b1;
    end else if (aligned < OMIN) begin
      nxt_out = OMIN[OP-1:0];
      nxt_udf = 1'b1;
    end else begin
      nxt_rnd = lost;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      rounded   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out     <= nxt_out;
        ovf     <= nxt_ovf;
        udf     <= nxt_udf;
        rounded <= nxt_rnd;
      end
    end
  end
endmodule

// File: tb/tb_fxp_calc.sv
// Scoreboard bench for fxp_calc in its default Q12.4 signed -> Q5.3 signed configuration.
module tb_fxp_calc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in = '0;
  logic        out_valid;
  logic [7:0]  out;
  logic        ovf, udf, rounded;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] out;
    logic       ovf;
    logic       udf;
    logic       rnd;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  fxp_calc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .out_valid(out_valid), .out(out), .ovf(ovf), .udf(udf), .rounded(rounded)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Floor division by 2 (one fractional bit dropped), then clamp to [-128, 127].
  function automatic exp_t model(input logic [15:0] x);
    exp_t r;
    int v, q, m;
    v = int'($signed(x));
    m = ((v % 2) + 2) % 2;
    q = (v - m) / 2;
    r.ovf = 1'b0; r.udf = 1'b0; r.rnd = 1'b0;
    if (q > 127) begin
      r.out = 8'h7F; r.ovf = 1'b1;
    end else if (q < -128) begin
      r.out = 8'h80; r.udf = 1'b1;
    end else begin
      r.out = q[7:0]; r.rnd = (m != 0);
    end
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in = 16'h0100;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out, ovf, udf, rounded} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got valid=%b out=%h ovf=%b udf=%b rnd=%b, required all 0",
               out_valid, out, ovf, udf, rounded);
    end
    reset = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [15:0] vin  [6] = '{16'h001C, 16'h0078, 16'h0011, 16'h0100, 16'hFF00, 16'hFEFF};
    logic [10:0] vexp [6] = '{{8'h0E, 3'b000}, {8'h3C, 3'b000}, {8'h08, 3'b001},
                              {8'h7F, 3'b100}, {8'h80, 3'b000}, {8'h80, 3'b010}};
    for (int i = 0; i < 6; i++) begin
      in = vin[i]; in_valid = 1'b1;
      e.out = vexp[i][10:3]; e.ovf = vexp[i][2]; e.udf = vexp[i][1]; e.rnd = vexp[i][0];
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out !== e.out || ovf !== e.ovf || udf !== e.udf || rounded !== e.rnd) begin
        errors++;
        $display("FAIL vector_%0d in=%h: got v=%b out=%h o/u/r=%b%b%b, required v=1 out=%h o/u/r=%b%b%b",
                 i, vin[i], out_valid, out, ovf, udf, rounded, e.out, e.ovf, e.udf, e.rnd);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    in = 16'h001C; in_valid = 1'b1;
    @(posedge clk); #1;
    in = 16'h0100; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || out !== 8'h0E || {ovf, udf, rounded} !== 3'b000) begin
        errors++;
        $display("FAIL hold_%0d: got v=%b out=%h o/u/r=%b%b%b, required v=0 out=0e o/u/r=000",
                 i, out_valid, out, ovf, udf, rounded);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [5] = '{16'h0011, 16'hFF00, 16'h0100, 16'h0002, 16'hFEFF};
    in = 16'h0100; in_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out, ovf, udf, rounded} !== 12'h000) begin
      errors++;
      $display("FAIL midstream_reset: got v=%b out=%h o/u/r=%b%b%b, required all 0",
               out_valid, out, ovf, udf, rounded);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in = seq[i]; in_valid = 1'b1;
      sb.push_back(model(seq[i]));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out !== e.out || ovf !== e.ovf || udf !== e.udf || rounded !== e.rnd) begin
        errors++;
        $display("FAIL back_to_back_%0d: got v=%b out=%h o/u/r=%b%b%b, required v=1 out=%h o/u/r=%b%b%b",
                 i, out_valid, out, ovf, udf, rounded, e.out, e.ovf, e.udf, e.rnd);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    exp_t last;
    logic v;
    last.out = out; last.ovf = ovf; last.udf = udf; last.rnd = rounded;
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       in = 16'($urandom_range(0, 511)) - 16'd256;
        1:       in = 16'($urandom_range(0, 1023)) - 16'd512;
        default: in = 16'($urandom);
      endcase
      in_valid = v;
      if (v) sb.push_back(model(in));
      @(posedge clk); #1;
      if (v) begin
        e = sb.pop_front();
        last = e;
      end else begin
        e = last;
      end
      checks++;
      if (out_valid !== v || out !== e.out || ovf !== e.ovf || udf !== e.udf || rounded !== e.rnd
          || (int'(ovf) + int'(udf) + int'(rounded)) > 1) begin
        errors++;
        $display("FAIL random_%0d: got v=%b out=%h o/u/r=%b%b%b, required v=%b out=%h o/u/r=%b%b%b",
                 i, out_valid, out, ovf, udf, rounded, v, e.out, e.ovf, e.udf, e.rnd);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_back_to_back();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
